conf_loader: RTL and testbench

- Replaces the fixed-tie-off channel configuration with a UART-driven frame decoder.
- Consumes the byte strobe stream from uart_rx (after its rising_edge_detector) and validates framed configuration packets.
- Commits each valid packet atomically into the per-channel configuration register of one channel, or of all channels.
- Parametrised in channel count, config width and inter-byte timeout; outputs feed the channel instances directly.

---
 rtl/conf_loader_pkg.sv | 21 ++
 rtl/conf_frame_timer.sv | 31 +++
 rtl/conf_loader.sv | 100 ++++++++++
 tb/tb_conf_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/conf_loader_pkg.sv
// Shared constants, state encoding and slot addressing for the UART
// configuration frame decoder.
package conf_loader_pkg;

   localparam logic [7:0] CONF_HDR   = 8'hA5;
   localparam logic [7:0] CONF_BCAST = 8'hFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INDEX   = 2'd1,
      PAYLOAD = 2'd2,
      CHECK   = 2'd3
   } conf_state_t;

   // Bit offset of channel slot idx inside the packed configuration vector.
   function automatic int unsigned slot_offset(input int unsigned idx,
                                               input int unsigned conf_bytes);
      return idx * conf_bytes * 8;
   endfunction

endpackage

// File: rtl/conf_frame_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is running and flags
// expiry on the last allowed idle cycle unless a byte arrives in that cycle.
module conf_frame_timer #(
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Saturates at LAST so a stalled owner never sees the count wrap.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_clear || !i_run) begin
         count <= '0;
      end else if (count != LAST) begin
         count <= count + 1'b1;
      end
   end

   assign o_expired = i_run && !i_clear && (count == LAST);

endmodule

// File: rtl/conf_loader.sv
// Decodes framed configuration packets (HDR, IDX, payload, CHK) from the UART
// byte strobe stream and commits each valid one atomically into channel slots.
module conf_loader
   import conf_loader_pkg::*;
#(
   parameter int CH_NO          = 4,
   parameter int CONF_BYTES     = 10,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter logic [CONF_BYTES*8-1:0] DEFAULT_CONF = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic [CH_NO*CONF_BYTES*8-1:0] o_conf,
   output logic [CH_NO-1:0]              o_updated,
   output logic                          o_err,
   output logic                          o_busy
);

   localparam int SLOT_W = CONF_BYTES * 8;
   localparam int BW     = (CONF_BYTES > 1) ? $clog2(CONF_BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(CONF_BYTES - 1);

   conf_state_t       state;
   logic [7:0]        idx;
   logic [7:0]        chk;
   logic [BW-1:0]     byte_cnt;
   logic [SLOT_W-1:0] shadow;
   logic              expired;
   logic              idx_ok;

   conf_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_valid),
      .i_run     (state != IDLE),
      .o_expired (expired)
   );

   assign idx_ok = (idx == CONF_BCAST) || (int'(idx) < CH_NO);
   assign o_busy = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         idx       <= '0;
         chk       <= '0;
         byte_cnt  <= '0;
         shadow    <= '0;
         o_conf    <= {CH_NO{DEFAULT_CONF}};
         o_updated <= '0;
         o_err     <= 1'b0;
      end else begin
         o_updated <= '0;
         o_err     <= 1'b0;
         if (i_valid) begin
            case (state)
               IDLE: begin
                  if (i_data == CONF_HDR) state <= INDEX;
               end
               INDEX: begin
                  idx      <= i_data;
                  chk      <= i_data;
                  byte_cnt <= '0;
                  state    <= PAYLOAD;
               end
               PAYLOAD: begin
                  shadow[byte_cnt*8 +: 8] <= i_data;
                  chk      <= chk ^ i_data;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_BYTE) state <= CHECK;
               end
               CHECK: begin
                  state <= IDLE;
                  // Slots only ever take a complete shadow image, never a partial frame.
                  if ((chk == i_data) && idx_ok) begin
                     for (int k = 0; k < CH_NO; k++) begin
                        if ((idx == CONF_BCAST) || (int'(idx) == k)) begin
                           o_conf[slot_offset(k, CONF_BYTES) +: SLOT_W] <= shadow;
                           o_updated[k] <= 1'b1;
                        end
                     end
                  end else begin
                     o_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (expired) begin
            state  <= IDLE;
            o_err  <= 1'b1;
            shadow <= '0;
         end
      end
   end

endmodule

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader: a driver pushes each expected commit/error
// event into a queue and a negedge monitor pops and compares DUT events.
module tb_conf_loader;

   localparam int CH_NO   = 4;
   localparam int CONF_W  = 320;
   localparam int TIMEOUT = 100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        data = 8'h00;
   logic              valid = 1'b0;
   logic [CONF_W-1:0] conf;
   logic [CH_NO-1:0]  updated;
   logic              err;
   logic              busy;

   typedef struct packed {
      logic [3:0]        upd;
      logic              err;
      logic [CONF_W-1:0] conf;
      logic [31:0]       cyc;
   } ev_t;

   ev_t               exp_q[$];
   ev_t               mon_e;
   logic [CONF_W-1:0] model_conf = '0;
   logic [31:0]       cyc = 0;
   logic [31:0]       last_edge = 0;
   int                n_checks = 0;
   int                n_fail = 0;

   conf_loader #(
      .CH_NO          (CH_NO),
      .CONF_BYTES     (10),
      .TIMEOUT_CYCLES (TIMEOUT),
      .DEFAULT_CONF   (80'h0)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (data),
      .i_valid   (valid),
      .o_conf    (conf),
      .o_updated (updated),
      .o_err     (err),
      .o_busy    (busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every commit or error pulse must match the head of the queue
   always @(negedge clk) begin
      if (!rst && (updated != '0 || err)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event upd=%b err=%b cyc=%0d", updated, err, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (updated !== mon_e.upd || err !== mon_e.err || busy !== 1'b0 ||
                conf !== mon_e.conf || cyc !== mon_e.cyc) begin
               n_fail++;
               $display("FAIL event got upd=%b err=%b busy=%b cyc=%0d conf=%h want upd=%b err=%b busy=0 cyc=%0d conf=%h",
                        updated, err, busy, cyc, conf, mon_e.upd, mon_e.err, mon_e.cyc, mon_e.conf);
            end
         end
      end
   end

   // driver tasks
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      valid = 1'b1;
      data  = b;
      @(posedge clk);
      #1;
      valid = 1'b0;
      last_edge = cyc;
   endtask

   task automatic send_frame(input logic [7:0] idx, input logic [79:0] p, input logic [7:0] chk);
      send(8'hA5);
      send(idx);
      for (int i = 0; i < 10; i++) send(p[i*8 +: 8]);
      send(chk);
   endtask

   task automatic expect_ev(input logic [3:0] upd, input logic e, input logic [31:0] at);
      exp_q.push_back('{upd: upd, err: e, conf: model_conf, cyc: at});
   endtask

   task automatic set_slot(input int k, input logic [79:0] v);
      model_conf[k*80 +: 80] = v;
   endtask

   task automatic check(input string name, input logic [CONF_W-1:0] got, input logic [CONF_W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_conf", conf, '0);
      check("reset_updated", CONF_W'(updated), '0);
      check("reset_err", CONF_W'(err), '0);
      check("reset_busy", CONF_W'(busy), '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // unicast to channel 2
      send_frame(8'h02, 80'h0A090807060504030201, 8'h09);
      set_slot(2, 80'h0A090807060504030201);
      expect_ev(4'b0100, 1'b0, last_edge);
      repeat (3) @(negedge clk);

      // broadcast
      send_frame(8'hFF, 80'h55555555555555555555, 8'hFF);
      for (int k = 0; k < 4; k++) set_slot(k, 80'h55555555555555555555);
      expect_ev(4'b1111, 1'b0, last_edge);
      repeat (3) @(negedge clk);

      // out-of-range channel with a correct checksum
      send_frame(8'h07, 80'h0A090807060504030201, 8'h0C);
      expect_ev(4'b0000, 1'b1, last_edge);
      repeat (3) @(negedge clk);

      // bad checksum
      send_frame(8'h02, 80'h0A090807060504030201, 8'h08);
      expect_ev(4'b0000, 1'b1, last_edge);
      repeat (3) @(negedge clk);

      // timeout after A5 01 03
      send(8'hA5);
      send(8'h01);
      send(8'h03);
      expect_ev(4'b0000, 1'b1, last_edge + TIMEOUT);
      repeat (50) @(negedge clk);
      check("busy_mid_frame", CONF_W'(busy), CONF_W'(1'b1));
      repeat (60) @(negedge clk);
      check("busy_after_timeout", CONF_W'(busy), '0);
      send_frame(8'h01, 80'h0A090807060504030201, 8'h0A);
      set_slot(1, 80'h0A090807060504030201);
      expect_ev(4'b0010, 1'b0, last_edge);
      repeat (3) @(negedge clk);

      // reset in mid-frame
      send(8'hA5);
      send(8'h03);
      for (int i = 1; i <= 5; i++) send(8'(i));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_conf = '0;
      check("midframe_reset_conf", conf, '0);
      check("midframe_reset_busy", CONF_W'(busy), '0);
      repeat (3) @(negedge clk);

      // stray bytes then a frame for channel 0
      send(8'h00);
      send(8'hA4);
      send_frame(8'h00, 80'h19181716151413121110, 8'h01);
      set_slot(0, 80'h19181716151413121110);
      expect_ev(4'b0001, 1'b0, last_edge);
      repeat (3) @(negedge clk);

      // a byte landing on the last allowed idle cycle is accepted
      send(8'hA5);
      send(8'h03);
      for (int i = 1; i <= 4; i++) send(8'(i));
      repeat (TIMEOUT - 1) @(negedge clk);
      for (int i = 5; i <= 10; i++) send(8'(i));
      send(8'h08);
      set_slot(3, 80'h0A090807060504030201);
      expect_ev(4'b1000, 1'b0, last_edge);

      repeat (20) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_events got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
